fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the RV32 core's instruction memory. Owns the program counter and issues one word read per cycle to the memory. Buffers returned words in a 2-entry FIFO toward decode under a valid/ready handshake. Handles branch/jump redirects, halt requests and out-of-range/misaligned PC faults.

---
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one-word reads and buffers responses in a 2-entry FIFO toward decode.
// Optional build macro FETCH_PERF_EN adds the perf_fetched / perf_stall counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

  state_t      state_r;
  logic [31:0] pc_r;
  logic        inflight_r;
  logic [31:0] tag_r;
  logic [31:0] fifo_instr_r [2];
  logic [31:0] fifo_pc_r    [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;

  logic pc_legal_s;
  logic pop_s;
  logic push_s;
  logic credit_s;
  logic issue_s;

  // Issue decision; credit counts this cycle's pop so a full stream sustains one word per cycle
  always_comb begin
    pc_legal_s = (pc_r[1:0] == 2'b00) && (pc_r[31:2] < DEPTH_WORDS);
    pop_s      = (count_r != 2'd0) && out_ready;
    push_s     = inflight_r && !redirect_valid;
    credit_s   = (({1'b0, count_r} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;
    if (!reset && (state_r == ST_RUN) && !redirect_valid && pc_legal_s && credit_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign imem_rd_en = issue_s;
  assign imem_addr  = {2'b00, pc_r[31:2]};
  assign halted     = (state_r == ST_HALTED);
  assign fault      = (state_r == ST_FAULT);
  assign out_valid  = (count_r != 2'd0);
  assign out_instr  = fifo_instr_r[rd_ptr_r];
  assign out_pc     = fifo_pc_r[rd_ptr_r];

  // Control state, PC and the single in-flight tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      inflight_r <= 1'b0;
      tag_r      <= 32'h0000_0000;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        tag_r <= pc_r;
      end else begin
        tag_r <= tag_r;
      end
      if (redirect_valid) begin
        pc_r    <= redirect_pc;
        state_r <= halt_req ? ST_HALTING : ST_RUN;
      end else begin
        if (issue_s) begin
          pc_r <= pc_r + 32'd4;
        end else begin
          pc_r <= pc_r;
        end
        case (state_r)
          ST_RUN: begin
            if (!pc_legal_s) begin
              state_r <= ST_FAULT;
            end else if (halt_req) begin
              state_r <= ST_HALTING;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_HALTING: state_r <= inflight_r ? ST_HALTING : ST_HALTED;
          ST_HALTED:  state_r <= halt_req ? ST_HALTED : ST_RUN;
          ST_FAULT:   state_r <= ST_FAULT;
          default:    state_r <= ST_RUN;
        endcase
      end
    end
  end

  // Output FIFO; a redirect drops both the buffered words and the response arriving this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_instr_r[0] <= 32'h0000_0000;
      fifo_instr_r[1] <= 32'h0000_0000;
      fifo_pc_r[0]    <= 32'h0000_0000;
      fifo_pc_r[1]    <= 32'h0000_0000;
      rd_ptr_r        <= 1'b0;
      wr_ptr_r        <= 1'b0;
      count_r         <= 2'd0;
    end else if (redirect_valid) begin
      wr_ptr_r <= rd_ptr_r;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_instr_r[wr_ptr_r] <= imem_rdata;
        fifo_pc_r[wr_ptr_r]    <= tag_r;
        wr_ptr_r               <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= (count_r + {1'b0, push_s}) - {1'b0, pop_s};
    end
  end

`ifdef FETCH_PERF_EN
  // Wrapping performance counters: accepted words and decode back-pressure cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0000_0000;
      perf_stall   <= 32'h0000_0000;
    end else begin
      if (pop_s) begin
        perf_fetched <= perf_fetched + 32'd1;
      end else begin
        perf_fetched <= perf_fetched;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end else begin
        perf_stall <= perf_stall;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table for streaming/backpressure, hand sequences for redirect, fault and halt.
// Accepted words are checked against a queue of expected byte PCs filled as each phase is driven.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        fault;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int total;
  int bad;
  int pops;
  logic [31:0] sb_q [$];

  typedef struct {
    logic        rdy;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [18];

  fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .halted(halted), .fault(fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word i holds 0x1000_0000 + i, one-cycle read latency
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'h1000_0000 + imem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
    @(negedge clk);
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    halt_req = hr;
    #1;
  endtask

  // Scoreboard: every accepted word must be the next expected PC with its memory word
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", out_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] epc;
        epc = sb_q.pop_front();
        chk("sb_pc", out_pc, epc);
        chk("sb_instr", out_instr, 32'h1000_0000 + (epc >> 2));
        pops++;
      end
    end
  end

  initial begin
    total = 0; bad = 0; pops = 0;
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd2, 1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd4};
    tbl[4]  = '{1'b0, 1'b0, 32'd4, 1'b1, 32'd8};
    for (int i = 5; i < 14; i++) tbl[i] = tbl[4];
    tbl[14] = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd8};
    tbl[15] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd12};
    tbl[16] = '{1'b1, 1'b1, 32'd6, 1'b1, 32'd16};
    tbl[17] = '{1'b1, 1'b1, 32'd7, 1'b1, 32'd20};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);

    // Streaming start, 10 cycles of backpressure, then release
    for (int k = 0; k < 6; k++) sb_q.push_back(32'(k * 4));
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b0;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rd_en", i), {31'd0, imem_rd_en}, {31'd0, tbl[i].exp_rd});
      if (tbl[i].exp_rd) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_v});
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), out_instr, 32'h1000_0000 + (tbl[i].exp_pc >> 2));
      end
    end

    // Redirect to 0x40 with a response in flight
    sb_q.push_back(32'h40);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    chk("redir_rd_en", {31'd0, imem_rd_en}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_n1_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_n1_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("redir_n1_addr", imem_addr, 32'd16);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_n2_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_n3_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_n3_pc", out_pc, 32'h40);
    chk("redir_n3_instr", out_instr, 32'h1000_0010);

    // Out-of-range redirect faults; halt_req ignored; redirect to 0 recovers
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    chk("oor_rd_en0", {31'd0, imem_rd_en}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("oor_rd_en1", {31'd0, imem_rd_en}, 32'd0);
    chk("oor_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("oor_fault", {31'd0, fault}, 32'd1);
    chk("oor_rd_en2", {31'd0, imem_rd_en}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("oor_fault_halt", {31'd0, fault}, 32'd1);
    chk("oor_no_halted", {31'd0, halted}, 32'd0);
    drive(1'b0, 1'b1, 32'h0, 1'b0);
    chk("oor_fault_hold", {31'd0, fault}, 32'd1);
    sb_q.push_back(32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("recov_fault", {31'd0, fault}, 32'd0);
    chk("recov_addr", imem_addr, 32'd0);
    chk("recov_rd_en", {31'd0, imem_rd_en}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("recov_valid", {31'd0, out_valid}, 32'd1);

    // Misaligned redirect
    drive(1'b0, 1'b1, 32'h6, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("mis_valid0", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("mis_valid1", {31'd0, out_valid}, 32'd0);

    // Halt mid-stream and resume
    drive(1'b1, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) sb_q.push_back(32'(k * 4));
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("halt_c0_addr", imem_addr, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt_req_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("halt_req_addr", imem_addr, 32'd3);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halting_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("halting_halted", {31'd0, halted}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halting2_halted", {31'd0, halted}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("halted_empty", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    chk("halted_hold_rd_en", {31'd0, imem_rd_en}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("halted_release", {31'd0, halted}, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    chk("resume_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("resume_addr", imem_addr, 32'd4);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("sb_pop_count", 32'(pops), 32'd14);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd14);
    chk("perf_stall", perf_stall, 32'd13);
`endif

    // Asynchronous reset while words are buffered
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'd0);
    chk("async_rst_pc", out_pc, 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
